// File: rtl/demux16_buf.sv
// Buffered 1-to-2 demultiplexer: steers each accepted word into channel A or B FIFO by s,
// with each channel draining over its own valid/ready handshake.
module demux16_buf #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       d,
  input  logic                   s,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_a,
  output logic                   a_valid,
  input  logic                   a_ready,
  output logic [$clog2(DEPTH):0] a_count,
  output logic [WIDTH-1:0]       out_b,
  output logic                   b_valid,
  input  logic                   b_ready,
  output logic [$clog2(DEPTH):0] b_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];

  logic [PtrW-1:0] a_wr_q, a_rd_q, b_wr_q, b_rd_q;
  logic [CntW-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic            push_a, push_b, pop_a, pop_b;

  assign a_valid  = (a_cnt_q != '0);
  assign b_valid  = (b_cnt_q != '0);
  assign a_count  = a_cnt_q;
  assign b_count  = b_cnt_q;
  // Readiness depends only on the selected channel's occupancy, never on consumer ready.
  assign in_ready = s ? (b_cnt_q != Full) : (a_cnt_q != Full);

  assign push_a = in_valid && in_ready && !s;
  assign push_b = in_valid && in_ready && s;
  assign pop_a  = a_valid && a_ready;
  assign pop_b  = b_valid && b_ready;

  assign out_a = a_valid ? mem_a[a_rd_q] : '0;
  assign out_b = b_valid ? mem_b[b_rd_q] : '0;

  always_comb begin
    a_cnt_d = a_cnt_q;
    if (push_a && !pop_a) begin
      a_cnt_d = a_cnt_q + 1'b1;
    end else if (pop_a && !push_a) begin
      a_cnt_d = a_cnt_q - 1'b1;
    end
  end

  always_comb begin
    b_cnt_d = b_cnt_q;
    if (push_b && !pop_b) begin
      b_cnt_d = b_cnt_q + 1'b1;
    end else if (pop_b && !push_b) begin
      b_cnt_d = b_cnt_q - 1'b1;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_wr_q  <= '0;
      a_rd_q  <= '0;
      a_cnt_q <= '0;
      b_wr_q  <= '0;
      b_rd_q  <= '0;
      b_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
      if (push_a) a_wr_q <= a_wr_q + 1'b1;
      if (pop_a)  a_rd_q <= a_rd_q + 1'b1;
      if (push_b) b_wr_q <= b_wr_q + 1'b1;
      if (pop_b)  b_rd_q <= b_rd_q + 1'b1;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_a) mem_a[a_wr_q] <= d;
    if (push_b) mem_b[b_wr_q] <= d;
  end

endmodule

// File: tb/tb_demux16_buf.sv
// Scoreboard bench for demux16_buf: stimulus queues expected words per channel,
// a negedge monitor pops and compares on every output handshake.
module tb_demux16_buf;

  logic        clk;
  logic        reset;
  logic [15:0] d;
  logic        s;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_a, out_b;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [1:0]  a_count, b_count;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  demux16_buf #(.WIDTH(16), .DEPTH(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .d        (d),
    .s        (s),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_a    (out_a),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_count  (a_count),
    .out_b    (out_b),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_count  (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake on an output channel must match the scoreboard head.
  always @(negedge clk) begin
    if (reset) begin
      if (a_valid && a_ready) begin
        if (exp_a.size() == 0) check("a_unexpected_pop", 32'(out_a), 32'hDEAD_0000);
        else check("a_order", 32'(out_a), 32'(exp_a.pop_front()));
      end
      if (b_valid && b_ready) begin
        if (exp_b.size() == 0) check("b_unexpected_pop", 32'(out_b), 32'hDEAD_0000);
        else check("b_order", 32'(out_b), 32'(exp_b.pop_front()));
      end
    end
  end

  // Called just after a posedge; returns just after the next posedge.
  task automatic push(input logic [15:0] v, input logic sel);
    logic rdy;
    d        = v;
    s        = sel;
    in_valid = 1'b1;
    @(negedge clk);
    rdy = in_ready;
    check("in_ready_push", 32'(rdy), 32'd1);
    @(posedge clk);
    if (rdy) begin
      if (sel) exp_b.push_back(v);
      else     exp_a.push_back(v);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    d        = '0;
    s        = 1'b0;
    in_valid = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;

    // 1. Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      d        = 16'($urandom);
      s        = 1'($urandom);
      in_valid = 1'($urandom);
      a_ready  = 1'($urandom);
      b_ready  = 1'($urandom);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("rst_out_a", 32'(out_a), 32'd0);
    check("rst_out_b", 32'(out_b), 32'd0);
    check("rst_a_count", 32'(a_count), 32'd0);
    check("rst_b_count", 32'(b_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);
    @(negedge clk);
    check("post_rst_a_valid", 32'(a_valid), 32'd0);
    check("post_rst_b_valid", 32'(b_valid), 32'd0);
    @(posedge clk);
    #1;

    // 2. Steering.
    push(16'h1234, 1'b0);
    push(16'hABCD, 1'b1);
    @(negedge clk);
    check("steer_a_count", 32'(a_count), 32'd1);
    check("steer_out_a", 32'(out_a), 32'h1234);
    check("steer_b_count", 32'(b_count), 32'd1);
    check("steer_out_b", 32'(out_b), 32'hABCD);
    @(posedge clk);
    #1;
    a_ready = 1'b1;
    b_ready = 1'b1;
    idle(1);
    a_ready = 1'b0;
    b_ready = 1'b0;
    @(negedge clk);
    check("drain_a_count", 32'(a_count), 32'd0);
    check("drain_b_count", 32'(b_count), 32'd0);
    @(posedge clk);
    #1;

    // 3. Full channel A; B still accepts.
    push(16'h0001, 1'b0);
    push(16'h0002, 1'b0);
    s        = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check("full_a_in_ready", 32'(in_ready), 32'd0);
    check("full_a_count", 32'(a_count), 32'd2);
    s = 1'b1;
    #1;
    check("full_b_sel_in_ready", 32'(in_ready), 32'd1);
    s = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("stalled_a_count", 32'(a_count), 32'd2);
    @(posedge clk);
    #1;
    push(16'h0003, 1'b1);
    @(negedge clk);
    check("b_accept_count", 32'(b_count), 32'd1);
    check("b_accept_out", 32'(out_b), 32'h0003);
    @(posedge clk);
    #1;

    // 4. Drain A in order.
    a_ready = 1'b1;
    @(negedge clk);
    check("drain_first", 32'(out_a), 32'h0001);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("drain_second", 32'(out_a), 32'h0002);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("drained_a_valid", 32'(a_valid), 32'd0);
    check("drained_out_a", 32'(out_a), 32'd0);
    @(posedge clk);
    #1;
    a_ready = 1'b0;

    // 5. Simultaneous push/pop on A, then wrap several times.
    push(16'h00AA, 1'b0);
    a_ready = 1'b1;
    push(16'h00FF, 1'b0);
    @(negedge clk);
    check("simul_a_count", 32'(a_count), 32'd1);
    check("simul_out_a", 32'(out_a), 32'h00FF);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      push(16'h0100 + 16'(i), 1'b0);
    end
    in_valid = 1'b0;
    idle(1);
    @(negedge clk);
    check("wrap_a_count", 32'(a_count), 32'd0);
    check("wrap_queue_empty", 32'(exp_a.size()), 32'd0);
    @(posedge clk);
    #1;
    a_ready = 1'b0;

    // 6. Asynchronous reset with both channels full.
    b_ready = 1'b1;
    idle(1);
    b_ready = 1'b0;
    push(16'h0A01, 1'b0);
    push(16'h0A02, 1'b0);
    push(16'h0B01, 1'b1);
    push(16'h0B02, 1'b1);
    @(negedge clk);
    check("prefull_a_count", 32'(a_count), 32'd2);
    check("prefull_b_count", 32'(b_count), 32'd2);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("async_a_valid", 32'(a_valid), 32'd0);
    check("async_b_valid", 32'(b_valid), 32'd0);
    check("async_a_count", 32'(a_count), 32'd0);
    check("async_b_count", 32'(b_count), 32'd0);
    check("async_out_a", 32'(out_a), 32'd0);
    exp_a.delete();
    exp_b.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);
    @(negedge clk);
    check("rel_a_valid", 32'(a_valid), 32'd0);
    check("rel_b_valid", 32'(b_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
